// File: rtl/stage2.sv
// stage2: class-session stage of the commute-and-class game.
// Turns the commute bonus into an energy budget and scores pop quizzes.
module stage2 #(
   parameter int CLASS_LEN  = 8,
   parameter int PASS_SCORE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pass1,
   input  logic [1:0] bonus1,
   input  logic [6:0] random2,
   input  logic [1:0] focus,
   output logic       busy,
   output logic       done,
   output logic       pass2,
   output logic [2:0] score
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CLASS,
      S_RESULT
   } state_t;

   localparam logic [4:0] LAST   = 5'(CLASS_LEN - 1);
   localparam logic [2:0] PSCORE = 3'(PASS_SCORE);

   state_t     r_state;
   logic       r_busy;
   logic       r_done;
   logic       r_pass2;
   logic [2:0] r_score;
   logic [2:0] r_energy;
   logic [1:0] r_strikes;
   logic       r_asleep;
   logic [4:0] r_cnt;

   logic [2:0] w_cost;
   logic       w_afford;
   logic [1:0] w_ef;
   logic       w_quiz;
   logic [2:0] w_score_nx;
   logic [1:0] w_strk_nx;
   logic       w_end;
   logic       w_unused;

   // Only the two low random bits decide whether a quiz happens.
   assign w_unused = ^random2[6:2];

   assign w_cost     = {2'b00, focus[1]} + {2'b00, focus[0]};
   assign w_afford   = !r_asleep && (w_cost <= r_energy);
   assign w_ef       = w_afford ? focus : 2'b00;
   assign w_quiz     = (random2[1:0] == 2'b11);
   assign w_score_nx = r_score + {2'b00, (w_quiz && (w_ef == 2'b11))};
   assign w_strk_nx  = r_strikes + {1'b0, (w_quiz && (w_ef == 2'b00))};
   assign w_end      = (w_strk_nx == 2'd2) || (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass2   <= 1'b0;
         r_score   <= 3'd0;
         r_energy  <= 3'd0;
         r_strikes <= 2'd0;
         r_asleep  <= 1'b0;
         r_cnt     <= 5'd0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy  <= 1'b1;
                  r_score <= 3'd0;
                  if (pass1) begin
                     r_state  <= S_LOAD;
                     r_energy <= 3'd3 + {1'b0, bonus1};
                  end else begin
                     r_state <= S_RESULT;
                     r_done  <= 1'b1;
                     r_pass2 <= 1'b0;
                  end
               end
            end
            S_LOAD: begin
               r_score   <= 3'd0;
               r_strikes <= 2'd0;
               r_asleep  <= 1'b0;
               r_cnt     <= 5'd0;
               r_state   <= S_CLASS;
            end
            S_CLASS: begin
               // An unaffordable focus puts the player to sleep for the session.
               if (!r_asleep && !w_afford) begin
                  r_asleep <= 1'b1;
               end
               if (w_afford) begin
                  r_energy <= r_energy - w_cost;
               end
               r_score   <= w_score_nx;
               r_strikes <= w_strk_nx;
               r_cnt     <= r_cnt + 5'd1;
               if (w_end) begin
                  r_state <= S_RESULT;
                  r_done  <= 1'b1;
                  r_pass2 <= (w_strk_nx < 2'd2) && (w_score_nx >= PSCORE);
               end
            end
            S_RESULT: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign pass2 = r_pass2;
   assign score = r_score;

endmodule

// File: tb/tb_stage2.sv
// tb_stage2: directed session bench for stage2 with a session-level model.
// A second instance covers the single-cycle, zero-threshold parameter corner.
module tb_stage2;

   localparam int LEN_A = 8;
   localparam int PS_A  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       pass1 = 1'b0;
   logic [1:0] bonus1 = 2'b00;
   logic [6:0] random2 = 7'd0;
   logic [1:0] focus = 2'b00;
   logic       busy;
   logic       done;
   logic       pass2;
   logic [2:0] score;

   logic       start_b = 1'b0;
   logic       pass1_b = 1'b0;
   logic [1:0] bonus1_b = 2'b00;
   logic [6:0] random2_b = 7'd0;
   logic [1:0] focus_b = 2'b00;
   logic       busy_b;
   logic       done_b;
   logic       pass2_b;
   logic [2:0] score_b;

   int n_run = 0;
   int n_fail = 0;
   int dk;

   always #5 clk = ~clk;

   stage2 #(.CLASS_LEN(LEN_A), .PASS_SCORE(PS_A)) u_dut (
      .clk(clk), .rst(rst), .start(start), .pass1(pass1),
      .bonus1(bonus1), .random2(random2), .focus(focus),
      .busy(busy), .done(done), .pass2(pass2), .score(score)
   );

   stage2 #(.CLASS_LEN(1), .PASS_SCORE(0)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .pass1(pass1_b),
      .bonus1(bonus1_b), .random2(random2_b), .focus(focus_b),
      .busy(busy_b), .done(done_b), .pass2(pass2_b), .score(score_b)
   );

   // expectations for the current cycle
   bit         chk_on = 1'b0;
   logic       e_busy, e_done, e_pass2;
   logic [2:0] e_score;
   bit         e_sc_chk, e_p2_chk;
   logic [2:0] h_score = 3'd0;
   logic       h_pass2 = 1'b0;

   // per-session stimulus and model timeline
   logic [1:0] s_foc [32];
   logic [6:0] s_rnd [32];
   int         m_n;
   logic       m_busy [40];
   logic       m_done [40];
   logic [2:0] m_sc_t [40];
   bit         m_scc [40];
   logic       m_p2_t [40];
   bit         m_p2c [40];
   logic [2:0] m_score;
   logic       m_pass;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         if (e_sc_chk) chk("score", score, e_score);
         if (e_p2_chk) chk("pass2", pass2, e_pass2);
      end
   end

   task automatic put(input int j, input logic b, input logic d,
                      input logic [2:0] s, input bit sc,
                      input logic p, input bit pc);
      m_busy[j] = b; m_done[j] = d;
      m_sc_t[j] = s; m_scc[j] = sc;
      m_p2_t[j] = p; m_p2c[j] = pc;
   endtask

   // Index j of the timeline is the cycle j+1 after the accepting edge.
   task automatic model(input logic p1, input logic [1:0] b1);
      int en, sc, st, c, cost;
      bit slp, quiz;
      logic [1:0] ef;
      if (!p1) begin
         put(0, 1, 1, 3'd0, 1, 1'b0, 1);
         m_n = 1; m_score = 3'd0; m_pass = 1'b0;
      end else begin
         put(0, 1, 0, 3'd0, 0, 1'b0, 0);
         en = 3 + int'(b1); sc = 0; st = 0; slp = 0; c = 0;
         while (1) begin
            put(c + 1, 1, 0, 3'(sc), 1, 1'b0, 0);
            cost = (s_foc[c] == 2'b00) ? 0 : (s_foc[c] == 2'b11) ? 2 : 1;
            if (slp) ef = 2'b00;
            else if (cost > en) begin slp = 1; ef = 2'b00; end
            else begin ef = s_foc[c]; en = en - cost; end
            quiz = (s_rnd[c][1:0] == 2'b11);
            if (quiz && ef == 2'b11) sc++;
            if (quiz && ef == 2'b00) st++;
            c++;
            if (st >= 2 || c >= LEN_A) break;
         end
         m_pass = (st < 2) && (sc >= PS_A);
         m_score = 3'(sc);
         put(c + 1, 1, 1, 3'(sc), 1, m_pass, 1);
         m_n = c + 2;
      end
   endtask

   task automatic idle_exp();
      e_busy = 0; e_done = 0;
      e_score = h_score; e_sc_chk = 1;
      e_pass2 = h_pass2; e_p2_chk = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         idle_exp();
         @(posedge clk); #1;
      end
   endtask

   task automatic fill(input logic [1:0] f, input logic [6:0] r);
      for (int i = 0; i < 32; i++) begin
         s_foc[i] = f; s_rnd[i] = r;
      end
   endtask

   task automatic session(input logic p1, input logic [1:0] b1,
                          input int ign_at, input int rs_at, input int post);
      bit aborted;
      aborted = 0;
      model(p1, b1);
      idle_exp();
      @(negedge clk);
      start = 1; pass1 = p1; bonus1 = b1;
      @(posedge clk); #1;
      start = 0; pass1 = 0; bonus1 = 2'b00;
      for (int j = 0; j < m_n; j++) begin
         e_busy = m_busy[j]; e_done = m_done[j];
         e_score = m_sc_t[j]; e_sc_chk = m_scc[j];
         e_pass2 = m_p2_t[j]; e_p2_chk = m_p2c[j];
         @(negedge clk);
         if (j >= 1) begin
            focus = s_foc[j - 1]; random2 = s_rnd[j - 1];
         end else begin
            focus = 2'b00; random2 = 7'd0;
         end
         start = (j == ign_at);
         if (j == rs_at) rst = 1;
         @(posedge clk); #1;
         start = 0;
         if (j == rs_at) begin
            aborted = 1;
            break;
         end
      end
      focus = 2'b00; random2 = 7'd0;
      if (aborted) begin
         h_score = 3'd0; h_pass2 = 1'b0;
         idle_exp();
         @(negedge clk); rst = 0;
         @(posedge clk); #1;
      end else begin
         h_score = m_score; h_pass2 = m_pass;
      end
      idle(post);
   endtask

   initial begin
      rst = 1;
      @(posedge clk); #1;
      idle_exp();
      chk_on = 1;
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      chk("reset score", score, 0);
      chk("reset pass2", pass2, 0);

      // commute failed: straight to RESULT
      fill(2'b00, 7'd0);
      session(1'b0, 2'b11, -1, -1, 2);
      chk("p1=0 len", m_n, 1);
      chk("p1=0 score", score, 0);
      chk("p1=0 pass2", pass2, 0);

      // full focus every cycle: sleep then early fail
      fill(2'b11, 7'h03);
      session(1'b1, 2'b11, -1, -1, 2);
      chk("sleep len", m_n, 7);
      chk("sleep model score", m_score, 3);
      chk("sleep score", score, 3);
      chk("sleep pass2", pass2, 0);

      // partial focus; start during RESULT ignored; back-to-back
      fill(2'b01, 7'h03);
      session(1'b1, 2'b00, 6, -1, 0);
      chk("partial len", m_n, 7);
      chk("partial score", score, 0);
      chk("partial pass2", pass2, 0);

      // pass at end, with a start pulse during CLASS
      fill(2'b00, 7'd0);
      s_foc[1] = 2'b11; s_rnd[1] = 7'h03;
      s_foc[5] = 2'b11; s_rnd[5] = 7'h03;
      session(1'b1, 2'b01, 3, -1, 2);
      chk("pass len", m_n, 10);
      chk("pass model", m_pass, 1);
      chk("pass score", score, 2);
      chk("pass pass2", pass2, 1);

      // reset in CLASS cycle 3 aborts the session
      fill(2'b00, 7'd0);
      s_foc[0] = 2'b11; s_rnd[0] = 7'h03;
      session(1'b1, 2'b10, -1, 4, 12);
      chk("abort score", score, 0);
      chk("abort pass2", pass2, 0);
      chk("abort busy", busy, 0);

      // CLASS_LEN=1, PASS_SCORE=0 instance
      @(negedge clk);
      start_b = 1; pass1_b = 1; bonus1_b = 2'b00;
      @(posedge clk); #2;
      start_b = 0; pass1_b = 0;
      chk("b busy T+1", busy_b, 1);
      dk = 0;
      for (int k = 1; k <= 10; k++) begin
         if (done_b) begin
            dk = k;
            break;
         end
         @(posedge clk); #2;
      end
      chk("b done cycle", dk, 3);
      chk("b pass2", pass2_b, 1);
      chk("b score", score_b, 0);
      @(posedge clk); #2;
      chk("b busy after", busy_b, 0);
      chk("b done after", done_b, 0);

      idle(2);
      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/stage2.md
# stage2

Second stage of the commute-and-class game. It consumes the `pass1`/`bonus1` result of the commute stage, converts the bonus into a starting energy budget, and runs a fixed-length class session cycle by cycle: pop quizzes driven by `random2`, player focus input, an energy budget, a sleep state and a strike count. At the end it reports a registered pass/fail and quiz score to the next stage.

## Interface

Parameters:
- `CLASS_LEN`, default 8: number of CLASS cycles per session; legal range 1..31.
- `PASS_SCORE`, default 2: minimum quiz score for `pass2`; legal range 0..3.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a session. Sampled only in IDLE.
- `pass1`, input, 1: commute-stage pass; sampled with `start`.
- `bonus1`, input, 2: commute-stage bonus; sampled with `start`.
- `random2`, input, 7: random word. A quiz occurs in a CLASS cycle when `random2[1:0]==2'b11`; bits [6:2] are unused.
- `focus`, input, 2: player focus level per CLASS cycle. Cost: 00→0, 01→1, 10→1, 11→2.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `done`, output, 1: one-cycle pulse in RESULT.
- `pass2`, output, 1: registered session result.
- `score`, output, 3: registered quiz score.

## Operation

- **States:** IDLE, LOAD, CLASS, RESULT.
- **IDLE:**
  - `start=1`, `pass1=0` → RESULT, with `pass2=0` and `score=0`. `bonus1` is ignored.
  - `start=1`, `pass1=1` → LOAD. Latch `energy = 3 + bonus1` (3 bits, range 3..6).
  - `start=0` → stay in IDLE. `pass2` and `score` hold.
- **LOAD:** clear `score`, `strikes` (2 bits), `asleep`, and the cycle counter (5 bits). Go to CLASS.
- **CLASS, each cycle:**
  - Effective focus `ef`:
    - 00 if `asleep=1`.
    - 00 if cost(`focus`) > `energy`. In this case set `asleep=1` (it stays set until the next LOAD) and leave `energy` unchanged.
    - Otherwise `ef = focus`, and `energy` decreases by cost(`focus`).
  - Quiz with `ef=11` → `score+1`. Quiz with `ef=00` → `strikes+1`. Quiz with `ef=01`/`10` → no change. No quiz → no score or strike change.
  - Cycle counter increments.
  - Leave CLASS for RESULT when `strikes` reaches 2 in this cycle (early fail) or the counter reaches `CLASS_LEN-1`, whichever comes first. If both happen in the same cycle, that cycle's quiz/strike update still applies.
- **RESULT:**
  - `done=1` for this cycle only.
  - For sessions entered from CLASS, `pass2 = (strikes<2) && (score>=PASS_SCORE)`.
  - Go to IDLE.
- **Arithmetic:**
  - `energy` never underflows, guaranteed by the affordability check.
  - `score` cannot exceed 3, because energy ≤ 6 and each scoring quiz costs 2. The 3-bit register needs no saturation.
- `start` while `busy=1` is ignored.

## Timing

- **Reset:** state = IDLE; `busy=0`, `done=0`, `pass2=0`, `score=0`; all internal registers 0. Reset mid-session aborts immediately, with no `done` pulse.
- **Latency, `pass1=0`:** `start` sampled at edge T → RESULT (`done=1`) during cycle T+1 → IDLE at T+2.
- **Latency, `pass1=1`, full length:** LOAD in T+1; CLASS in T+2 .. T+1+`CLASS_LEN`; `done` in T+2+`CLASS_LEN`.
- **Latency, early fail:** `done` in the cycle after the CLASS cycle in which `strikes` reaches 2.
- `pass2`/`score` update on entry to RESULT and hold until the next accepted `start`. During LOAD/CLASS, `score` shows the running value.
- `busy` goes high the cycle after `start` is accepted and low the cycle after RESULT.
- **Back-to-back:** a `start` asserted during RESULT is ignored. A new session can be accepted in the first IDLE cycle.

## Test plan

- **`pass1=0` fail:** reset, then `pass1=0`, `start=1` at T → `done=1`, `pass2=0`, `score=0` in T+1; `busy=1` only in T+1.
- **Pass at end of session:** `pass1=1`, `bonus1=01` (energy 4), `CLASS_LEN=8`. Quiz (`random2=7'h03`) with `focus=11` in CLASS cycles 1 and 5; `random2=0`, `focus=00` elsewhere → `done` at T+10, `score=2`, `pass2=1`.
- **Sleep and early fail:** `bonus1=11` (energy 6), quiz every cycle, `focus=11` always → score 3 in CLASS cycles 0–2; asleep from cycle 3 (strike 1); strike 2 in cycle 4 → `done` at T+7, `score=3`, `pass2=0`.
- **Partial focus:** `bonus1=00` (energy 3), quiz every cycle, `focus=01` always → cycles 0–2 no change; cycle 3 asleep (strike 1); cycle 4 strike 2 → `done` at T+7, `score=0`, `pass2=0`.
- **Start ignored and reset abort:** `start` pulsed during CLASS → ignored, session timing unchanged. `rst=1` in CLASS cycle 3 → next cycle `busy=0`, `done=0`, `score=0`, `pass2=0`, and no later `done`.
- **Parameter edges:** `CLASS_LEN=1`, `PASS_SCORE=0`, no quiz → `done` at T+3, `pass2=1`, `score=0`.
